// File: rtl/nn_layer_seq_if.sv
// Host/distributor/activation handshake bundle for the layer sequencer.
interface nn_layer_seq_if #(
  parameter int unsigned MAX_LAYERS = 8,
  parameter int unsigned LAYER_W    = 4
);
  logic                  start;
  logic                  abort;
  logic [LAYER_W-1:0]    cfg_layers;
  logic [MAX_LAYERS-1:0] act_mask;
  logic                  all_done;
  logic                  act_done;

  logic                  dis_en;
  logic [LAYER_W-1:0]    layer_index;
  logic                  need_act;
  logic                  act_en;
  logic                  busy;
  logic                  done;
  logic                  err;

  // Host side: drives requests and unit completions, observes sequencer status
  modport master (
    output start, abort, cfg_layers, act_mask, all_done, act_done,
    input  dis_en, layer_index, need_act, act_en, busy, done, err
  );

  // Sequencer side
  modport slave (
    input  start, abort, cfg_layers, act_mask, all_done, act_done,
    output dis_en, layer_index, need_act, act_en, busy, done, err
  );
endinterface

// File: rtl/nn_layer_seq.sv
// Multi-layer run controller: pulses the distributor once per layer, optionally
// runs an activation pass per layer, with watchdog, abort and completion pulse.
module nn_layer_seq #(
  parameter int unsigned MAX_LAYERS = 8,
  parameter int unsigned LAYER_W    = 4,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned TMR_W      = 11
) (
  input  logic          l_clk,
  input  logic          rst,
  nn_layer_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_CONV,
    S_ACT_ISSUE,
    S_WAIT_ACT,
    S_ADVANCE,
    S_OUT
  } state_t;

  state_t                r_state;
  logic                  r_dis_en;
  logic [LAYER_W-1:0]    r_layer_index;
  logic                  r_need_act;
  logic                  r_act_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [TMR_W-1:0]      r_wdog;
  logic [LAYER_W-1:0]    r_cfg_q;
  logic [MAX_LAYERS-1:0] r_mask_q;

  logic                  w_cfg_ok;
  logic                  w_tmo;
  logic                  w_last;
  logic                  w_next_need;

  // Layer count accepted only in 1..MAX_LAYERS; anything else completes empty
  assign w_cfg_ok    = (bus.cfg_layers != '0) &&
                       (bus.cfg_layers <= LAYER_W'(MAX_LAYERS));
  assign w_tmo       = (r_wdog == TMR_W'(TIMEOUT - 1));
  assign w_last      = (r_layer_index == r_cfg_q);
  // Mask bit for the layer after the current one (1-based index L selects bit L)
  assign w_next_need = |(r_mask_q & (MAX_LAYERS'(1) << r_layer_index));

  // Sequencer state and registered outputs
  always_ff @(posedge l_clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_dis_en      <= 1'b0;
      r_layer_index <= '0;
      r_need_act    <= 1'b0;
      r_act_en      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_wdog        <= '0;
      r_cfg_q       <= '0;
      r_mask_q      <= '0;
    end else begin
      r_dis_en <= 1'b0;
      r_act_en <= 1'b0;
      r_done   <= 1'b0;

      if ((r_state != S_IDLE) && bus.abort) begin
        // Abort beats every completion and the watchdog; no done pulse
        r_state       <= S_IDLE;
        r_busy        <= 1'b0;
        r_layer_index <= '0;
        r_need_act    <= 1'b0;
        r_wdog        <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_busy        <= 1'b0;
            r_layer_index <= '0;
            r_wdog        <= '0;
            if (bus.start && !bus.abort) begin
              r_err  <= 1'b0;
              r_busy <= 1'b1;
              if (w_cfg_ok) begin
                r_cfg_q       <= bus.cfg_layers;
                r_mask_q      <= bus.act_mask;
                r_layer_index <= LAYER_W'(1);
                r_need_act    <= bus.act_mask[0];
                r_dis_en      <= 1'b1;
                r_state       <= S_ISSUE;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_OUT;
              end
            end
          end

          S_ISSUE: begin
            r_wdog  <= '0;
            r_state <= S_WAIT_CONV;
          end

          S_WAIT_CONV: begin
            if (bus.all_done) begin
              if (r_need_act) begin
                r_act_en <= 1'b1;
                r_state  <= S_ACT_ISSUE;
              end else begin
                r_state  <= S_ADVANCE;
              end
            end else if (w_tmo) begin
              r_err         <= 1'b1;
              r_state       <= S_IDLE;
              r_busy        <= 1'b0;
              r_layer_index <= '0;
              r_need_act    <= 1'b0;
              r_wdog        <= '0;
            end else begin
              r_wdog <= r_wdog + TMR_W'(1);
            end
          end

          S_ACT_ISSUE: begin
            r_wdog  <= '0;
            r_state <= S_WAIT_ACT;
          end

          S_WAIT_ACT: begin
            if (bus.act_done) begin
              r_state <= S_ADVANCE;
            end else if (w_tmo) begin
              r_err         <= 1'b1;
              r_state       <= S_IDLE;
              r_busy        <= 1'b0;
              r_layer_index <= '0;
              r_need_act    <= 1'b0;
              r_wdog        <= '0;
            end else begin
              r_wdog <= r_wdog + TMR_W'(1);
            end
          end

          S_ADVANCE: begin
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_OUT;
            end else begin
              r_layer_index <= r_layer_index + LAYER_W'(1);
              r_need_act    <= w_next_need;
              r_dis_en      <= 1'b1;
              r_wdog        <= '0;
              r_state       <= S_ISSUE;
            end
          end

          S_OUT: begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_layer_index <= '0;
            r_need_act    <= 1'b0;
          end

          default: begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_layer_index <= '0;
            r_need_act    <= 1'b0;
            r_wdog        <= '0;
          end
        endcase
      end
    end
  end

  assign bus.dis_en      = r_dis_en;
  assign bus.layer_index = r_layer_index;
  assign bus.need_act    = r_need_act;
  assign bus.act_en      = r_act_en;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;

endmodule
